march_bist_ctrl: RTL and testbench

MARCH_BIST_CTRL -- requirements
Module: march_bist_ctrl

---
 rtl/march_bist_pkg.sv | 60 ++++++
 rtl/march_addr_counter.sv | 49 ++++
 rtl/march_bist_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_march_bist_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/march_bist_pkg.sv
// Shared definitions for the March C- BIST controller: FSM states, element
// indices and the per-element direction / operation / polarity tables.
package march_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [2:0] E0 = 3'd0;
  localparam logic [2:0] E1 = 3'd1;
  localparam logic [2:0] E2 = 3'd2;
  localparam logic [2:0] E3 = 3'd3;
  localparam logic [2:0] E4 = 3'd4;
  localparam logic [2:0] E5 = 3'd5;

  // Memory operations per word over the whole March C- run.
  localparam int unsigned OPS_PER_WORD = 10;

  // Tables indexed by element number (bit e describes element Ee).
  localparam logic [5:0] ELEM_DOWN      = 6'b011000; // E3, E4 walk downwards
  localparam logic [5:0] ELEM_HAS_READ  = 6'b111110; // E1..E5 read
  localparam logic [5:0] ELEM_HAS_WRITE = 6'b011111; // E0..E4 write
  localparam logic [5:0] ELEM_RD_POL    = 6'b010100; // E2, E4 expect all-1s
  localparam logic [5:0] ELEM_WR_POL    = 6'b001010; // E1, E3 write all-1s

  // Look up one element's entry in a table; out-of-range elements read as 0.
  function automatic logic elem_flag(input logic [5:0] tbl, input logic [2:0] e);
    logic f;
    case (e)
      3'd0:    f = tbl[0];
      3'd1:    f = tbl[1];
      3'd2:    f = tbl[2];
      3'd3:    f = tbl[3];
      3'd4:    f = tbl[4];
      3'd5:    f = tbl[5];
      default: f = 1'b0;
    endcase
    return f;
  endfunction

  // Elements that read then write each address before advancing.
  function automatic logic elem_two_op(input logic [2:0] e);
    return elem_flag(ELEM_HAS_READ, e) & elem_flag(ELEM_HAS_WRITE, e);
  endfunction

  // Whether the op selected by (element, phase) is a write.
  function automatic logic op_is_write(input logic [2:0] e, input logic phase);
    logic w;
    if (elem_two_op(e)) begin
      w = phase;
    end else begin
      w = elem_flag(ELEM_HAS_WRITE, e);
    end
    return w;
  endfunction

endpackage

// File: rtl/march_addr_counter.sv
// Address sequencer for the March walk: loadable up/down counter that holds
// at the end of its range and flags the terminal address for the direction.
module march_addr_counter #(
  parameter int ARRAY_SIZE = 16,
  parameter int ADDR_WIDTH = $clog2(ARRAY_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_zero,
  input  logic                  load_max,
  input  logic                  step,
  input  logic                  down,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  tc
);

  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(ARRAY_SIZE - 1);

  logic [ADDR_WIDTH-1:0] addr_d;
  logic [ADDR_WIDTH-1:0] addr_q;

  // Terminal count: last address of the walk in the current direction.
  assign tc   = down ? (addr_q == '0) : (addr_q == MAX_ADDR);
  assign addr = addr_q;

  // Next address: loads win over stepping; never step past either end.
  always_comb begin
    addr_d = addr_q;
    if (load_zero) begin
      addr_d = '0;
    end else if (load_max) begin
      addr_d = MAX_ADDR;
    end else if (step && !tc) begin
      addr_d = down ? (addr_q - ADDR_WIDTH'(1)) : (addr_q + ADDR_WIDTH'(1));
    end else begin
      addr_d = addr_q;
    end
  end

  // Address register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/march_bist_ctrl.sv
// March C- memory BIST controller. Issues one memory op per cycle while
// running, compares each read one cycle later against a registered expected
// word, and records the first mismatch. All outputs come straight from flops.
module march_bist_ctrl
  import march_bist_pkg::*;
#(
  parameter int ARRAY_SIZE = 16,
  parameter int ADDR_WIDTH = $clog2(ARRAY_SIZE),
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_e                state_d, state_q;
  logic [2:0]            elem_d, elem_q;
  logic                  phase_d, phase_q;       // 0: first op at this address
  logic                  busy_d, busy_q;
  logic                  done_d, done_q;
  logic                  mem_en_d, mem_en_q;
  logic                  mem_we_d, mem_we_q;
  logic [DATA_WIDTH-1:0] mem_wdata_d, mem_wdata_q;
  logic                  rd_pend_d, rd_pend_q;   // a read was on the bus last cycle
  logic                  exp_d, exp_q;           // polarity expected for that read
  logic [ADDR_WIDTH-1:0] cmp_addr_d, cmp_addr_q;
  logic [2:0]            cmp_elem_d, cmp_elem_q;
  logic                  fail_d, fail_q;
  logic [ADDR_WIDTH-1:0] fail_addr_d, fail_addr_q;
  logic [2:0]            fail_elem_d, fail_elem_q;

  logic                  cnt_load_zero, cnt_load_max, cnt_step, cnt_down, cnt_tc;
  logic [ADDR_WIDTH-1:0] cnt_addr;
  logic                  start_ok;
  logic                  mismatch;

  march_addr_counter #(
    .ARRAY_SIZE (ARRAY_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr (
    .clk       (clk),
    .rst       (rst),
    .load_zero (cnt_load_zero),
    .load_max  (cnt_load_max),
    .step      (cnt_step),
    .down      (cnt_down),
    .addr      (cnt_addr),
    .tc        (cnt_tc)
  );

  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign cnt_down = elem_flag(ELEM_DOWN, elem_q);
  assign mismatch = rd_pend_q && (mem_rdata != {DATA_WIDTH{exp_q}});

  // Sequencer: state, element and phase transitions plus counter control.
  always_comb begin
    logic [2:0] nxt_elem;
    state_d       = state_q;
    elem_d        = elem_q;
    phase_d       = phase_q;
    cnt_load_zero = 1'b0;
    cnt_load_max  = 1'b0;
    cnt_step      = 1'b0;
    nxt_elem      = elem_q + 3'd1;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d       = ST_RUN;
          elem_d        = E0;
          phase_d       = 1'b0;
          cnt_load_zero = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (elem_two_op(elem_q) && !phase_q) begin
          phase_d = 1'b1;                      // write follows read, same address
        end else if (cnt_tc) begin
          phase_d = 1'b0;
          if (elem_q == E5) begin
            state_d = ST_DRAIN;
          end else begin
            elem_d = nxt_elem;
            if (elem_flag(ELEM_DOWN, nxt_elem)) begin
              cnt_load_max = 1'b1;
            end else begin
              cnt_load_zero = 1'b1;
            end
          end
        end else begin
          phase_d  = 1'b0;
          cnt_step = 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values for the registered status and memory-strobe outputs.
  always_comb begin
    busy_d      = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d      = (state_d == ST_DONE);
    mem_en_d    = (state_d == ST_RUN);
    mem_we_d    = mem_en_d && op_is_write(elem_d, phase_d);
    mem_wdata_d = '0;
    if (mem_we_d) begin
      mem_wdata_d = {DATA_WIDTH{elem_flag(ELEM_WR_POL, elem_d)}};
    end else begin
      mem_wdata_d = '0;
    end
  end

  // Read-compare pipeline and first-failure capture.
  always_comb begin
    rd_pend_d   = mem_en_q && !mem_we_q;
    exp_d       = elem_flag(ELEM_RD_POL, elem_q);
    cmp_addr_d  = cnt_addr;
    cmp_elem_d  = elem_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    if (start_ok) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_elem_d = 3'd0;
    end else if (mismatch && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = cmp_addr_q;
      fail_elem_d = cmp_elem_q;
    end else begin
      fail_d = fail_q;
    end
  end

  // State and output registers; reset aborts any test immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      elem_q      <= E0;
      phase_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rd_pend_q   <= 1'b0;
      exp_q       <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= 3'd0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      phase_q     <= phase_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rd_pend_q   <= rd_pend_d;
      exp_q       <= exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = cnt_addr;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Self-checking bench for march_bist_ctrl: a 16-word instance with a faulty
// memory model and a 4-word instance with a clean one, checked against a
// March C- reference computed directly from the algorithm definition.
module tb_march_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-word instance
  logic       rst16, start16, busy16, done16, fail16, en16, we16;
  logic [3:0] faddr16, addr16;
  logic [2:0] felem16;
  logic [7:0] wdata16, rdata16;
  // 4-word instance
  logic       rst4, start4, busy4, done4, fail4, en4, we4;
  logic [1:0] faddr4, addr4;
  logic [2:0] felem4;
  logic [7:0] wdata4, rdata4;

  march_bist_ctrl #(.ARRAY_SIZE(16), .DATA_WIDTH(8)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .busy(busy16), .done(done16),
    .fail(fail16), .fail_addr(faddr16), .fail_elem(felem16), .mem_en(en16),
    .mem_we(we16), .mem_addr(addr16), .mem_wdata(wdata16), .mem_rdata(rdata16));

  march_bist_ctrl #(.ARRAY_SIZE(4), .DATA_WIDTH(8)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .busy(busy4), .done(done4),
    .fail(fail4), .fail_addr(faddr4), .fail_elem(felem4), .mem_en(en4),
    .mem_we(we4), .mem_addr(addr4), .mem_wdata(wdata4), .mem_rdata(rdata4));

  // mode 0: none; 1: stuck-at (a=word, b=bit, v=value); 2: write to a also writes b
  typedef struct { int mode; int a; int b; int v; } fault_t;
  typedef struct { fault_t f; int mid; int ef; int ea; int ee; } vec_t;

  fault_t cur_fault;
  logic [7:0] mem16 [16];
  logic [7:0] mem4  [4];
  int exp_ops[$];
  int obs_ops[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [7:0] fault_read(input fault_t f, input int a, input logic [7:0] d);
    logic [7:0] r;
    logic [7:0] mask;
    r = d;
    mask = 8'd1 << f.b;
    if (f.mode == 1 && a == f.a) r = (f.v != 0) ? (d | mask) : (d & ~mask);
    return r;
  endfunction

  // Memory models: read data is registered, valid the cycle after the strobe.
  always @(posedge clk) begin
    if (en16) begin
      if (we16) begin
        mem16[addr16] <= wdata16;
        if (cur_fault.mode == 2 && int'(addr16) == cur_fault.a) mem16[cur_fault.b] <= wdata16;
      end else begin
        rdata16 <= fault_read(cur_fault, int'(addr16), mem16[addr16]);
      end
    end
    if (en4) begin
      if (we4) mem4[addr4] <= wdata4;
      else     rdata4 <= mem4[addr4];
    end
  end

  logic sel_r = 1'b0;
  logic s_busy, s_done, s_fail, s_en, s_we;
  int   s_addr, s_wdata, s_faddr, s_felem;
  assign s_busy  = sel_r ? busy4 : busy16;
  assign s_done  = sel_r ? done4 : done16;
  assign s_fail  = sel_r ? fail4 : fail16;
  assign s_en    = sel_r ? en4   : en16;
  assign s_we    = sel_r ? we4   : we16;
  assign s_addr  = sel_r ? int'(addr4)  : int'(addr16);
  assign s_wdata = sel_r ? int'(wdata4) : int'(wdata16);
  assign s_faddr = sel_r ? int'(faddr4) : int'(faddr16);
  assign s_felem = sel_r ? int'(felem4) : int'(felem16);

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // March C- reference: op list (encoded) and first failing read for fault f.
  task automatic ref_model(input int n, input fault_t f, output int ef, output int ea, output int ee);
    logic [7:0] m [16];
    int rd_pol [6] = '{-1, 0, 1, 0, 1, 0};
    int wr_pol [6] = '{ 0, 1, 0, 1, 0, -1};
    int dn     [6] = '{ 0, 0, 0, 1, 1, 0};
    ef = 0; ea = 0; ee = 0;
    exp_ops.delete();
    foreach (m[i]) m[i] = 8'h5a;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < n; i++) begin
        int a;
        a = (dn[e] != 0) ? (n - 1 - i) : i;
        if (rd_pol[e] >= 0) begin
          logic [7:0] want;
          want = (rd_pol[e] != 0) ? 8'hff : 8'h00;
          exp_ops.push_back(a * 10);
          if (fault_read(f, a, m[a]) != want && ef == 0) begin
            ef = 1; ea = a; ee = e;
          end
        end
        if (wr_pol[e] >= 0) begin
          logic [7:0] d;
          d = (wr_pol[e] != 0) ? 8'hff : 8'h00;
          m[a] = d;
          if (f.mode == 2 && a == f.a) m[f.b] = d;
          exp_ops.push_back(1000 + a * 10 + wr_pol[e]);
        end
      end
    end
  endtask

  // One full test on the selected instance; exp_ops must already be filled.
  task automatic run_test(input int sel, input int n, input int mid,
                          input int ef, input int ea, input int ee);
    int t_busy, t_done, nmis;
    sel_r = (sel != 0);
    @(negedge clk);
    if (sel != 0) start4 = 1'b1; else start16 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; start16 = 1'b0;
    obs_ops.delete();
    t_busy = -1; t_done = -1;
    for (int k = 0; k < 400; k++) begin
      if (k == 0) chk("start_entry_busy_done_fail_en", {s_busy, s_done, s_fail, s_en}, 4'b1001);
      if (s_busy && t_busy < 0) t_busy = k;
      if (s_en) begin
        if (s_we) obs_ops.push_back(1000 + s_addr * 10 +
                                    (s_wdata == 255 ? 1 : (s_wdata == 0 ? 0 : 5)));
        else      obs_ops.push_back(s_addr * 10);
      end
      if (s_done) begin
        t_done = k;
        break;
      end
      if (sel != 0) start4 = (mid != 0 && k == 50);
      else          start16 = (mid != 0 && k == 50);
      @(negedge clk);
    end
    start4 = 1'b0; start16 = 1'b0;
    chk("op_count", obs_ops.size(), 10 * n);
    nmis = 0;
    for (int i = 0; i < exp_ops.size(); i++)
      if (i >= obs_ops.size() || obs_ops[i] != exp_ops[i]) nmis++;
    chk("op_stream_mismatches", nmis, 0);
    if (obs_ops.size() > 5 * n) chk("e3_first_op", obs_ops[5 * n], (n - 1) * 10);
    chk("done_latency", (t_done < 0) ? -1 : (t_done - t_busy), 10 * n + 1);
    chk("fail", s_fail, ef);
    chk("fail_addr", s_faddr, ea);
    chk("fail_elem", s_felem, ee);
    repeat (3) @(negedge clk);
    chk("done_hold_idle_bus", {s_done, s_busy, s_en, s_we}, 4'b1000);
  endtask

  task automatic set_vec(output vec_t v, input int mode, input int a, input int b, input int fv,
                         input int mid, input int ef, input int ea, input int ee);
    v.f.mode = mode; v.f.a = a; v.f.b = b; v.f.v = fv;
    v.mid = mid; v.ef = ef; v.ea = ea; v.ee = ee;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [5];
    fault_t f;
    int ef, ea, ee, cnt;

    set_vec(vecs[0], 0, 0, 0, 0, 0, 0, 0, 0);   // clean memory
    set_vec(vecs[1], 1, 5, 0, 1, 0, 1, 5, 1);   // word 5 bit 0 stuck-at-1 -> E1 r0 @5
    set_vec(vecs[2], 2, 9, 3, 0, 1, 1, 3, 3);   // write 9 corrupts 3 -> E3 r0 @3, start mid-run
    set_vec(vecs[3], 1, 12, 7, 0, 0, 1, 12, 2); // word 12 bit 7 stuck-at-0 -> E2 r1 @12
    set_vec(vecs[4], 0, 0, 0, 0, 1, 0, 0, 0);   // clean again after a failing test

    cur_fault = '{0, 0, 0, 0};
    rst16 = 1'b0; rst4 = 1'b0; start16 = 1'b0; start4 = 1'b0;
    #12;
    chk("reset_outputs_16", int'({busy16, done16, fail16, en16, we16, addr16, wdata16, faddr16, felem16}), 0);
    chk("reset_outputs_4",  int'({busy4, done4, fail4, en4, we4, addr4, wdata4, faddr4, felem4}), 0);
    @(negedge clk);
    rst16 = 1'b1; rst4 = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      cur_fault = vecs[i].f;
      ref_model(16, vecs[i].f, ef, ea, ee);
      run_test(0, 16, vecs[i].mid, vecs[i].ef, vecs[i].ea, vecs[i].ee);
    end

    for (int i = 0; i < 8; i++) begin
      f.mode = $urandom_range(0, 2);
      f.a    = $urandom_range(0, 15);
      f.b    = (f.mode == 2) ? ((f.a + $urandom_range(1, 15)) % 16) : $urandom_range(0, 7);
      f.v    = $urandom_range(0, 1);
      cur_fault = f;
      ref_model(16, f, ef, ea, ee);
      run_test(0, 16, $urandom_range(0, 1), ef, ea, ee);
    end

    // Reset in the middle of a failing test.
    cur_fault = '{1, 5, 0, 1};
    sel_r = 1'b0;
    @(negedge clk); start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    repeat (70) @(negedge clk);
    chk("fail_before_abort", fail16, 1);
    chk("addr_at_op70", int'(addr16), 11);
    #2 rst16 = 1'b0;
    #1;
    chk("async_reset_outputs", int'({busy16, done16, fail16, en16, we16, addr16, wdata16, faddr16, felem16}), 0);
    @(negedge clk);
    rst16 = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (en16 || busy16) cnt++;
    end
    chk("no_activity_after_reset", cnt, 0);
    cur_fault = '{0, 0, 0, 0};
    ref_model(16, cur_fault, ef, ea, ee);
    run_test(0, 16, 0, 0, 0, 0);

    // Small array: wrap only at element boundaries, 40 ops.
    ref_model(4, '{0, 0, 0, 0}, ef, ea, ee);
    run_test(1, 4, 0, 0, 0, 0);
    ref_model(4, '{0, 0, 0, 0}, ef, ea, ee);
    run_test(1, 4, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
